// File: rtl/sra_unit.sv
// ---------------------------------------------------------------------------
// sra_unit
//   Registered arithmetic right shift (sign-extending) built as a log-depth
//   barrel shifter. One clock of latency and a new operand every cycle.
//
// Ports
//   clk        in   1      single clock, rising edge
//   reset      in   1      synchronous, active-high
//   in_valid   in   1      qualifies A / shamt this cycle
//   A          in   WIDTH  two's-complement operand
//   shamt      in   SHW    unsigned shift amount, 0..WIDTH-1
//   SRAResult  out  WIDTH  registered A >>> shamt
//   carry_out  out  1      registered last bit shifted out (A[shamt-1], 0 for shamt=0)
//   zero       out  1      registered SRAResult == 0
//   negative   out  1      registered SRAResult[WIDTH-1]
//   out_valid  out  1      output registers hold a result from a valid input
// ---------------------------------------------------------------------------
module sra_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4      // must equal $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] SRAResult,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             out_valid
);

    // The operand is widened by one guard bit below the LSB. Shifting the
    // widened word leaves the last bit shifted out of A in the guard
    // position, so carry_out falls out of the same shifter: for shamt=0
    // the guard bit is the appended 0, for shamt=n it is A[n-1].
    logic [WIDTH:0] w_stage [0:SHW];

    assign w_stage[0] = {A, 1'b0};

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int STEP = 1 << k;
        // Each stage shifts by 2^k and refills the top with the sign bit.
        assign w_stage[k+1] = shamt[k]
                            ? {{STEP{w_stage[k][WIDTH]}}, w_stage[k][WIDTH:STEP]}
                            : w_stage[k];
    end

    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_stage[SHW][WIDTH:1];
                r_carry  <= w_stage[SHW][0];
            end
        end
    end

    // Flags come straight off the result register, so no input reaches an
    // output without passing through a flop.
    assign SRAResult = r_result;
    assign carry_out = r_carry;
    assign zero      = (r_result == '0);
    assign negative  = r_result[WIDTH-1];
    assign out_valid = r_valid;

endmodule

// File: tb/tb_sra_unit.sv
module tb_sra_unit;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] SRAResult;
    logic             carry_out;
    logic             zero;
    logic             negative;
    logic             out_valid;

    int total = 0;
    int bad   = 0;

    sra_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .A         (A),
        .shamt     (shamt),
        .SRAResult (SRAResult),
        .carry_out (carry_out),
        .zero      (zero),
        .negative  (negative),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, let one rising edge capture, sample 1 ns later.
    task automatic step(input logic rst, input logic v, input logic [WIDTH-1:0] a,
                        input logic [SHW-1:0] sh);
        @(negedge clk);
        reset    = rst;
        in_valid = v;
        A        = a;
        shamt    = sh;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] res,
                             input logic c, input logic z, input logic n, input logic ov);
        check({tag, ".res"},  32'(SRAResult), 32'(res));
        check({tag, ".c"},    32'(carry_out), 32'(c));
        check({tag, ".z"},    32'(zero),      32'(z));
        check({tag, ".n"},    32'(negative),  32'(n));
        check({tag, ".ov"},   32'(out_valid), 32'(ov));
    endtask

    initial begin
        logic signed [WIDTH-1:0] sa;
        logic [WIDTH-1:0]        ra;
        logic [WIDTH-1:0]        exp_res;
        logic                    exp_c;

        reset = 1'b1; in_valid = 1'b0; A = '0; shamt = '0;

        // Reset together with a valid input: input is discarded.
        step(1'b1, 1'b1, 16'h1234, 4'd3);
        check_all("rst_with_valid", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);

        step(1'b0, 1'b1, 16'h000F, 4'd1);
        check_all("a000f_s1", 16'h0007, 1'b1, 1'b0, 1'b0, 1'b1);

        step(1'b0, 1'b1, 16'h8E8E, 4'd1);
        check_all("a8e8e_s1", 16'hC747, 1'b0, 1'b0, 1'b1, 1'b1);

        // Back-to-back: 0x008E >>> 2 then >>> 3.
        step(1'b0, 1'b1, 16'h008E, 4'd2);
        check_all("a008e_s2", 16'h0023, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h008E, 4'd3);
        check_all("a008e_s3", 16'h0011, 1'b1, 1'b0, 1'b0, 1'b1);

        // in_valid low: data holds, out_valid drops.
        step(1'b0, 1'b0, 16'hFFFF, 4'd7);
        check_all("hold", 16'h0011, 1'b1, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 16'h8002, 4'd1);
        check_all("a8002_s1", 16'hC001, 1'b0, 1'b0, 1'b1, 1'b1);

        step(1'b0, 1'b1, 16'h8000, 4'd15);
        check_all("a8000_s15", 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1);

        step(1'b0, 1'b1, 16'h0001, 4'd1);
        check_all("a0001_s1", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);

        step(1'b0, 1'b1, 16'h7FFF, 4'd15);
        check_all("a7fff_s15", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);

        step(1'b0, 1'b1, 16'hA5A5, 4'd0);
        check_all("aa5a5_s0", 16'hA5A5, 1'b0, 1'b0, 1'b1, 1'b1);

        // Mid-stream reset, then first valid input after release.
        step(1'b0, 1'b1, 16'h1235, 4'd0);
        check_all("pre_rst", 16'h1235, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 16'hFFFF, 4'd1);
        check_all("mid_rst", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'hF000, 4'd4);
        check_all("post_rst", 16'hFF00, 1'b0, 1'b0, 1'b1, 1'b1);

        // Random operands over every shift amount against a >>> reference.
        for (int sh = 0; sh < 16; sh++) begin
            for (int r = 0; r < 4; r++) begin
                ra      = WIDTH'($urandom());
                if (r == 0) ra[WIDTH-1] = 1'b1;
                if (r == 1) ra[WIDTH-1] = 1'b0;
                sa      = ra;
                exp_res = sa >>> sh;
                exp_c   = (sh == 0) ? 1'b0 : ra[sh-1];
                step(1'b0, 1'b1, ra, SHW'(sh));
                check($sformatf("rnd_s%0d_a%04h.res", sh, ra), 32'(SRAResult), 32'(exp_res));
                check($sformatf("rnd_s%0d_a%04h.c", sh, ra),   32'(carry_out), 32'(exp_c));
                check($sformatf("rnd_s%0d_a%04h.z", sh, ra),   32'(zero),      32'(exp_res == '0));
                check($sformatf("rnd_s%0d_a%04h.n", sh, ra),   32'(negative),  32'(exp_res[WIDTH-1]));
                check($sformatf("rnd_s%0d_a%04h.ov", sh, ra),  32'(out_valid), 32'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
